nlfsr3_ctrl: RTL and testbench

NLFSR3_CTRL -- requirements
Module: nlfsr3_ctrl

---
 rtl/nlfsr3_ctrl.sv | 142 ++++++++++++++
 tb/tb_nlfsr3_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nlfsr3_ctrl.sv
// Sequencer for an NLFSR3 keystream core: seed load, tweaked init rounds, then packed keystream output.
// Latency: first word OUT_W+1 cycles after RUN entry; stalls the NLFSR while a full word waits on ks_ready.
module nlfsr3_ctrl #(
    parameter int INIT_ROUNDS = 24,
    parameter int OUT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [29:0]      seed,
    input  logic [4:0]       tk_in,
    output logic             load,
    output logic             init,
    output logic             nlfsr3_ce,
    output logic [4:0]       d3,
    output logic [4:0]       tk,
    input  logic             o_warbler,
    output logic [OUT_W-1:0] ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_INIT, ST_RUN} state_t;

    state_t           state;
    logic [24:0]      seed_sr;
    logic [4:0]       tk_q;
    logic [2:0]       lcnt;
    logic [7:0]       rcnt;
    logic [OUT_W-1:0] col;
    logic [5:0]       cnt;

    logic             full;
    logic             xfer;
    logic [OUT_W-1:0] col_n;
    logic [5:0]       cnt_n;
    logic             vld_n;

    // Collector next-state: a word handover and a new bit can happen in the same cycle.
    always_comb begin
        full  = (cnt == 6'(OUT_W));
        xfer  = full && (!ks_valid || ks_ready);
        col_n = col;
        cnt_n = cnt;
        if (xfer) begin
            col_n = '0;
            cnt_n = 6'd0;
        end
        if (nlfsr3_ce) begin
            col_n = {col_n[OUT_W-2:0], o_warbler};
            cnt_n = cnt_n + 6'd1;
        end
        vld_n = xfer ? 1'b1 : (ks_ready ? 1'b0 : ks_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            seed_sr   <= '0;
            tk_q      <= '0;
            lcnt      <= '0;
            rcnt      <= '0;
            col       <= '0;
            cnt       <= '0;
            load      <= 1'b0;
            init      <= 1'b0;
            nlfsr3_ce <= 1'b0;
            d3        <= '0;
            tk        <= '0;
            ks_data   <= '0;
            ks_valid  <= 1'b0;
            busy      <= 1'b0;
        end else if (stop) begin
            state     <= ST_IDLE;
            lcnt      <= '0;
            rcnt      <= '0;
            col       <= '0;
            cnt       <= '0;
            load      <= 1'b0;
            init      <= 1'b0;
            nlfsr3_ce <= 1'b0;
            d3        <= '0;
            tk        <= '0;
            ks_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        seed_sr   <= seed[29:5];
                        tk_q      <= tk_in;
                        lcnt      <= '0;
                        load      <= 1'b1;
                        nlfsr3_ce <= 1'b1;
                        d3        <= seed[4:0];
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (lcnt == 3'd5) begin
                        state <= ST_INIT;
                        rcnt  <= '0;
                        load  <= 1'b0;
                        d3    <= '0;
                        init  <= 1'b1;
                        tk    <= tk_q;
                    end else begin
                        lcnt    <= lcnt + 3'd1;
                        d3      <= seed_sr[4:0];
                        seed_sr <= seed_sr >> 5;
                    end
                end
                ST_INIT: begin
                    if (rcnt == 8'(INIT_ROUNDS - 1)) begin
                        state <= ST_RUN;
                        init  <= 1'b0;
                        tk    <= '0;
                        col   <= '0;
                        cnt   <= '0;
                    end else begin
                        rcnt <= rcnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    col      <= col_n;
                    cnt      <= cnt_n;
                    ks_valid <= vld_n;
                    if (xfer) begin
                        ks_data <= col;
                    end
                    // Pause the NLFSR before a bit could arrive with nowhere to go.
                    nlfsr3_ce <= !((cnt_n == 6'(OUT_W)) && vld_n);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nlfsr3_ctrl.sv
// Directed bench for nlfsr3_ctrl with a small behavioural NLFSR3 driving o_warbler.
module tb_nlfsr3_ctrl;

    localparam logic [29:0] SEED_A = 30'h2AAAAAAA;
    localparam logic [4:0]  TK_A   = 5'h13;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [29:0] seed;
    logic [4:0] tk_in;
    logic       load;
    logic       init;
    logic       nlfsr3_ce;
    logic [4:0] d3;
    logic [4:0] tk;
    logic       o_warbler;
    logic [7:0] ks_data;
    logic       ks_valid;
    logic       ks_ready;
    logic       busy;

    int tests;
    int fails;

    logic [7:0]  ew [0:11];
    logic [29:0] ms;

    nlfsr3_ctrl #(.INIT_ROUNDS(24), .OUT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .seed      (seed),
        .tk_in     (tk_in),
        .load      (load),
        .init      (init),
        .nlfsr3_ce (nlfsr3_ce),
        .d3        (d3),
        .tk        (tk),
        .o_warbler (o_warbler),
        .ks_data   (ks_data),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] nstep(input logic [29:0] s, input logic [4:0] t);
        logic fb;
        fb = s[29] ^ s[20] ^ (s[11] & s[3]) ^ (^t);
        return {s[28:0], fb};
    endfunction

    function automatic logic nout(input logic [29:0] s);
        return s[29] ^ s[14] ^ (s[5] & s[22]);
    endfunction

    // Reference NLFSR3: cells shift in from the top on load so C0 ends up holding the first word.
    always @(posedge clk or posedge rst) begin
        if (rst)
            ms <= '0;
        else if (load)
            ms <= {d3, ms[29:5]};
        else if (nlfsr3_ce)
            ms <= nstep(ms, init ? tk : 5'd0);
    end
    assign o_warbler = nout(ms);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_init(input logic [29:0] s, input logic [4:0] t);
        logic [29:0] sh;
        seed  = s;
        tk_in = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        seed  = '0;
        tk_in = '0;
        for (int k = 0; k < 6; k++) begin
            sh = s >> (5 * k);
            chk("load_ctl", 32'({load, init, nlfsr3_ce, busy}), 32'hB);
            chk("load_d3", 32'(d3), 32'(sh[4:0]));
            chk("load_tk", 32'(tk), 32'h0);
            tick();
        end
        for (int r = 0; r < 24; r++) begin
            chk("init_ctl", 32'({load, init, nlfsr3_ce, busy}), 32'h7);
            chk("init_tk", 32'(tk), 32'(t));
            chk("init_d3", 32'(d3), 32'h0);
            tick();
        end
        chk("run_entry", 32'({load, init, nlfsr3_ce, busy, ks_valid}), 32'h6);
        chk("run_entry_tk", 32'({d3, tk}), 32'h0);
    endtask

    initial begin
        logic [29:0] s;
        logic [7:0]  w;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        seed     = '0;
        tk_in    = '0;
        ks_ready = 1'b1;

        s = SEED_A;
        for (int r = 0; r < 24; r++) s = nstep(s, TK_A);
        for (int i = 0; i < 12; i++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                w = {w[6:0], nout(s)};
                s = nstep(s, 5'd0);
            end
            ew[i] = w;
        end

        #2;
        chk("rst_ctl", 32'({load, init, nlfsr3_ce, busy, ks_valid}), 32'h0);
        chk("rst_dat", 32'({d3, tk, ks_data}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequence from the first edge after reset, then four words at full rate.
        load_init(SEED_A, TK_A);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("first_gap", 32'(ks_valid), 32'h0);
        end
        tick();
        chk("w0_vld", 32'(ks_valid), 32'h1);
        chk("w0_dat", 32'(ks_data), 32'(ew[0]));
        for (int wi = 1; wi < 4; wi++) begin
            for (int i = 0; i < 7; i++) begin
                tick();
                chk("gap", 32'({ks_valid, nlfsr3_ce}), 32'h1);
            end
            tick();
            chk("wn_vld", 32'(ks_valid), 32'h1);
            chk("wn_dat", 32'(ks_data), 32'(ew[wi]));
        end

        // Backpressure for 20 cycles on word 3.
        ks_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            chk("bp_vld", 32'(ks_valid), 32'h1);
            chk("bp_dat", 32'(ks_data), 32'(ew[3]));
            chk("bp_ce", 32'(nlfsr3_ce), (j < 7) ? 32'h1 : 32'h0);
            if (j == 19) ks_ready = 1'b1;
            tick();
        end
        chk("w4_vld", 32'({ks_valid, nlfsr3_ce}), 32'h3);
        chk("w4_dat", 32'(ks_data), 32'(ew[4]));

        // A start while running must not disturb the stream.
        seed  = 30'h0;
        tk_in = 5'h1F;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            chk("run_start_ctl", 32'({load, init, busy, ks_valid}), 32'h2);
        end
        tick();
        chk("w5_vld", 32'(ks_valid), 32'h1);
        chk("w5_dat", 32'(ks_data), 32'(ew[5]));

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_run", 32'({load, init, nlfsr3_ce, busy, ks_valid}), 32'h0);

        // Stop together with start on init cycle 10.
        seed  = 30'h12345678;
        tk_in = 5'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("init10_ctl", 32'({load, init, nlfsr3_ce, busy}), 32'h7);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("stop_init", 32'({load, init, nlfsr3_ce, busy}), 32'h0);
        chk("stop_init_dat", 32'({d3, tk}), 32'h0);
        tick();
        chk("stop_start_ign", 32'({load, busy}), 32'h0);

        // Reset in load cycle 3, then a full fresh sequence.
        seed  = SEED_A;
        tk_in = TK_A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("load3_d3", 32'({load, d3}), 32'h35);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ctl", 32'({load, init, nlfsr3_ce, busy, ks_valid}), 32'h0);
        chk("arst_dat", 32'({d3, tk, ks_data}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        load_init(SEED_A, TK_A);
        for (int i = 0; i < 8; i++) tick();
        tick();
        chk("rerun_w0_vld", 32'(ks_valid), 32'h1);
        chk("rerun_w0_dat", 32'(ks_data), 32'(ew[0]));
        for (int i = 0; i < 8; i++) tick();
        chk("rerun_w1_dat", 32'({ks_valid, ks_data}), 32'({1'b1, ew[1]}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
